bus_rr_arbiter: RTL and testbench

Round-robin arbiter and turn sequencer for the shared parallel bus linking the `drvrs` device interfaces. It grants the bus to one requesting device at a time and pulses `trn_chng` on every change of owner. It qualifies bus writes with `wrt`, then decodes the destination field of each word into per-device receive strobes, including broadcast. It sits beside the device interfaces and their FIFOs and is the only source of bus ownership.

---
 rtl/bus_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with turn sequencing and destination decode into per-device receive strobes.
// Define BUS_ARB_BURST_EN to allow up to max_burst words per turn; otherwise every turn is a single word.
module bus_rr_arbiter #(
    parameter int         drvrs     = 4,
    parameter int         bits      = 32,
    parameter logic [7:0] bdcst     = 8'hFF,
    parameter int         max_burst = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [drvrs-1:0]         req_i,
    input  logic [bits-1:0]          bus_i,
    output logic [drvrs-1:0]         grant_o,
    output logic [$clog2(drvrs)-1:0] owner_o,
    output logic                     trn_chng_o,
    output logic                     wrt_o,
    output logic [drvrs-1:0]         rx_push_o,
    output logic [bits-1:0]          rx_data_o,
    output logic                     misroute_o
);
    localparam int OW = $clog2(drvrs);

    typedef enum logic [1:0] {IDLE, XFER, TURN} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            trn_q, trn_d;
    logic [drvrs-1:0] push_d, rx_push_q;
    logic [bits-1:0] rx_data_q;
    logic            misroute_q, bad_dest;
    logic            win_vld;
    logic [OW-1:0]   win_idx;
    logic            last_word;
    logic [7:0]      dest;

`ifdef BUS_ARB_BURST_EN
    localparam int CW = (max_burst > 1) ? $clog2(max_burst) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign last_word = (cnt_q == CW'(max_burst - 1));
`else
    assign last_word = 1'b1;
`endif

    assign wrt_o = (state_q == XFER) && req_i[owner_q];
    assign dest  = bus_i[bits-1 -: 8];

    // First requester at or above ptr, wrapping around.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int i = 0; i < drvrs; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= drvrs) idx = idx - drvrs;
            if (!win_vld && req_i[idx]) begin
                win_vld = 1'b1;
                win_idx = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        trn_d   = 1'b0;
`ifdef BUS_ARB_BURST_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d = win_idx;
                    trn_d   = 1'b1;
                    state_d = XFER;
`ifdef BUS_ARB_BURST_EN
                    cnt_d   = '0;
`endif
                end
            end
            XFER: begin
`ifdef BUS_ARB_BURST_EN
                if (wrt_o) cnt_d = cnt_q + 1'b1;
`endif
                // wrt equals req[owner] here, so a written last word or a dropped request ends the turn
                if (!req_i[owner_q] || last_word) state_d = TURN;
            end
            TURN: begin
                ptr_d   = (owner_q == OW'(drvrs - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_o = '0;
        if (state_q == XFER) grant_o[owner_q] = 1'b1;
    end

    // Sender never receives its own word; broadcast reaches everyone else.
    always_comb begin
        push_d   = '0;
        bad_dest = 1'b0;
        for (int k = 0; k < drvrs; k++) begin
            if (k != int'(owner_q) && (dest == bdcst || int'(dest) == k))
                push_d[k] = wrt_o;
        end
        if (wrt_o && dest != bdcst && int'(dest) >= drvrs) bad_dest = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            trn_q      <= 1'b0;
            rx_push_q  <= '0;
            rx_data_q  <= '0;
            misroute_q <= 1'b0;
`ifdef BUS_ARB_BURST_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            trn_q     <= trn_d;
            rx_push_q <= push_d;
            if (wrt_o) rx_data_q <= bus_i;
            if (bad_dest) misroute_q <= 1'b1;
`ifdef BUS_ARB_BURST_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign owner_o    = owner_q;
    assign trn_chng_o = trn_q;
    assign rx_push_o  = rx_push_q;
    assign rx_data_o  = rx_data_q;
    assign misroute_o = misroute_q;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: reset, fairness, burst/turn timing, delivery decode, misroute, early release.
module tb_bus_rr_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] bus;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        trn_chng, wrt, misroute;
    logic [3:0]  rx_push;
    logic [31:0] rx_data;

    int passed = 0;
    int total  = 0;

`ifdef BUS_ARB_BURST_EN
    localparam int WPT = 4;
`else
    localparam int WPT = 1;
`endif

    bus_rr_arbiter #(.drvrs(4), .bits(32), .bdcst(8'hFF), .max_burst(4)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .bus_i(bus),
        .grant_o(grant), .owner_o(owner), .trn_chng_o(trn_chng), .wrt_o(wrt),
        .rx_push_o(rx_push), .rx_data_o(rx_data), .misroute_o(misroute)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first post-reset cycle (state IDLE, ptr 0).
    task automatic do_reset();
        reset = 1'b1; req = '0; bus = '0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b1111; bus = 32'hFF00_00A5;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({grant, owner, trn_chng, wrt, rx_push, rx_data, misroute} !== '0)
                $display("FAIL reset_outputs cyc%0d: grant=%b owner=%0d trn=%b wrt=%b push=%b data=%h mis=%b",
                         c, grant, owner, trn_chng, wrt, rx_push, rx_data, misroute);
            else passed++;
        end
        reset = 1'b0;
        step();
        total++; if (grant !== 4'b0001) $display("FAIL reset_release_grant: got %b want 0001", grant); else passed++;
        total++; if (trn_chng !== 1'b1) $display("FAIL reset_release_trn: got %b want 1", trn_chng); else passed++;
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111; bus = 32'h0300_0000;
        for (int g = 0; g < 5; g++) begin
            for (int w = 0; w < WPT; w++) begin
                step();
                total++;
                if (grant !== exp_g[g] || trn_chng !== (w == 0) || wrt !== 1'b1)
                    $display("FAIL fair_grant%0d_w%0d: grant=%b trn=%b wrt=%b want grant=%b trn=%b wrt=1",
                             g, w, grant, trn_chng, wrt, exp_g[g], (w == 0));
                else passed++;
            end
            step();
            total++;
            if (grant !== 4'b0000 || wrt !== 1'b0 || owner !== 2'(g % 4))
                $display("FAIL fair_turn%0d: grant=%b wrt=%b owner=%0d want 0000/0/%0d", g, grant, wrt, owner, g % 4);
            else passed++;
            step();
        end
        req = '0;
    endtask

    task automatic test_burst();
        int remaining = 6;
        int n;
        do_reset();
        req = 4'b0100; bus = 32'h0000_0011;
        while (remaining > 0) begin
            n = (remaining < WPT) ? remaining : WPT;
            for (int i = 0; i < n; i++) begin
                step();
                total++;
                if (grant !== 4'b0100 || trn_chng !== (i == 0) || wrt !== 1'b1)
                    $display("FAIL burst_word%0d_%0d: grant=%b trn=%b wrt=%b want 0100/%b/1",
                             remaining, i, grant, trn_chng, wrt, (i == 0));
                else passed++;
            end
            remaining -= n;
            if (n < WPT) begin
                step();
                req = '0;
                #1;
                total++;
                if (grant !== 4'b0100 || wrt !== 1'b0)
                    $display("FAIL burst_release: grant=%b wrt=%b want 0100/0", grant, wrt);
                else passed++;
            end
            step();
            if (remaining == 0) req = '0;
            total++;
            if (grant !== 4'b0000 || wrt !== 1'b0)
                $display("FAIL burst_turn%0d: grant=%b wrt=%b want 0000/0", remaining, grant, wrt);
            else passed++;
            step();
            total++;
            if (grant !== 4'b0000) $display("FAIL burst_idle%0d: grant=%b want 0000", remaining, grant); else passed++;
        end
    endtask

    task automatic test_broadcast();
        do_reset();
        req = 4'b0010; bus = 32'hFF00_00A5;
        step();
        total++; if (grant !== 4'b0010 || wrt !== 1'b1) $display("FAIL bcast_grant: grant=%b wrt=%b want 0010/1", grant, wrt); else passed++;
        step();
        req = '0;
        total++; if (rx_push !== 4'b1101) $display("FAIL bcast_push: got %b want 1101", rx_push); else passed++;
        total++; if (rx_data[7:0] !== 8'hA5) $display("FAIL bcast_data: got %h want a5", rx_data[7:0]); else passed++;
        total++; if (misroute !== 1'b0) $display("FAIL bcast_misroute: got %b want 0", misroute); else passed++;
    endtask

    task automatic test_unicast_misroute();
        do_reset();
        req = 4'b0001; bus = 32'h0312_3456;
        step();
        total++; if (wrt !== 1'b1) $display("FAIL uni_wrt: got %b want 1", wrt); else passed++;
        step();
        req = '0;
        total++; if (rx_push !== 4'b1000) $display("FAIL uni_push: got %b want 1000", rx_push); else passed++;
        total++; if (rx_data !== 32'h0312_3456) $display("FAIL uni_data: got %h want 03123456", rx_data); else passed++;
        total++; if (misroute !== 1'b0) $display("FAIL uni_misroute: got %b want 0", misroute); else passed++;

        // Sender addressing itself: no push, no misroute.
        do_reset();
        req = 4'b0001; bus = 32'h0000_0001;
        step();
        step();
        req = '0;
        total++; if (rx_push !== 4'b0000 || misroute !== 1'b0)
            $display("FAIL self_dest: push=%b mis=%b want 0000/0", rx_push, misroute); else passed++;

        do_reset();
        req = 4'b0001; bus = 32'h0700_0000;
        step();
        step();
        req = '0;
        total++; if (rx_push !== 4'b0000) $display("FAIL mis_push: got %b want 0000", rx_push); else passed++;
        total++; if (misroute !== 1'b1) $display("FAIL mis_set: got %b want 1", misroute); else passed++;
        repeat (6) step();
        total++; if (misroute !== 1'b1) $display("FAIL mis_sticky: got %b want 1", misroute); else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (misroute !== 1'b0) $display("FAIL mis_reset: got %b want 0", misroute); else passed++;
    endtask

    task automatic test_early_release();
`ifdef BUS_ARB_BURST_EN
        localparam int WORDS = 2;
`else
        localparam int WORDS = 1;
`endif
        do_reset();
        req = 4'b1000; bus = 32'h0100_0000;
        for (int i = 0; i < WORDS; i++) begin
            step();
            total++;
            if (grant !== 4'b1000 || wrt !== 1'b1)
                $display("FAIL early_word%0d: grant=%b wrt=%b want 1000/1", i, grant, wrt);
            else passed++;
            req = 4'b1011;
        end
        if (WORDS < WPT) begin
            step();
            req = 4'b0011;
            #1;
            total++; if (wrt !== 1'b0) $display("FAIL early_drop_wrt: got %b want 0", wrt); else passed++;
        end
        step();
        total++; if (grant !== 4'b0000) $display("FAIL early_turn: grant=%b want 0000", grant); else passed++;
        step();
        total++; if (grant !== 4'b0000) $display("FAIL early_idle: grant=%b want 0000", grant); else passed++;
        step();
        total++; if (grant !== 4'b0001 || trn_chng !== 1'b1)
            $display("FAIL early_next: grant=%b trn=%b want 0001/1", grant, trn_chng); else passed++;
        req = '0;
    endtask

    initial begin
        reset = 1'b1; req = '0; bus = '0;
        test_reset();
        test_fairness();
        test_burst();
        test_broadcast();
        test_unicast_misroute();
        test_early_release();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
